// File: rtl/fab_clk_en_gen_pkg.sv
// Shared types and defaults for the fabric clock-enable generator.
package fab_clk_en_gen_pkg;

    localparam int unsigned FAB_CLK_DIV_W   = 16;
    localparam int unsigned FAB_CLK_DEF_DIV = 50;

    typedef logic [FAB_CLK_DIV_W-1:0] fab_clk_div_t;

    typedef struct packed {
        fab_clk_div_t div_a;
        fab_clk_div_t div_p;
        logic         pend;
        fab_clk_div_t cnt;
    } fab_clk_ch_state_t;

endpackage

// File: rtl/fab_clk_en_ch.sv
// One clock-enable channel: down-counter, pending divisor and optional divide-by-2 toggle.
// CLK_TGL flop exists only when FAB_CLK_EN_GEN_TOGGLE_EN is defined.
module fab_clk_en_ch
    import fab_clk_en_gen_pkg::*;
#(
    parameter int unsigned DIV_W   = FAB_CLK_DIV_W,
    parameter int unsigned DEF_DIV = FAB_CLK_DEF_DIV
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             wr_i,
    input  logic [DIV_W-1:0] wr_data_i,
    output logic             busy_o,
    output logic             tick_o,
    output logic             tgl_o
);

    // Same layout as fab_clk_ch_state_t, sized for this instance's DIV_W.
    typedef struct packed {
        logic [DIV_W-1:0] div_a;
        logic [DIV_W-1:0] div_p;
        logic             pend;
        logic [DIV_W-1:0] cnt;
    } ch_state_t;

    localparam logic [DIV_W-1:0] DefDiv = DIV_W'(DEF_DIV);
    localparam ch_state_t ResetSt = '{
        div_a: DefDiv,
        div_p: DefDiv,
        pend:  1'b0,
        cnt:   DefDiv - 1'b1
    };

    ch_state_t        st_q, st_d;
    logic             tick_q, tick_d;
    logic [DIV_W-1:0] div_new;

    always_comb begin
        div_new = st_q.pend ? st_q.div_p : st_q.div_a;
        st_d    = st_q;
        tick_d  = 1'b0;
        if (sync_i || !en_i) begin
            st_d.div_a = div_new;
            st_d.pend  = 1'b0;
            st_d.cnt   = div_new - 1'b1;
        end else if (st_q.div_a == '0) begin
            // Parked: counter frozen until a new divisor arrives.
            if (st_q.pend) begin
                st_d.div_a = st_q.div_p;
                st_d.pend  = 1'b0;
                st_d.cnt   = st_q.div_p - 1'b1;
            end
        end else if (st_q.cnt == '0) begin
            tick_d     = 1'b1;
            st_d.div_a = div_new;
            st_d.pend  = 1'b0;
            st_d.cnt   = div_new - 1'b1;
        end else begin
            st_d.cnt = st_q.cnt - 1'b1;
        end
        // A write lands after any apply above, so it is never consumed this cycle.
        if (wr_i) begin
            st_d.div_p = wr_data_i;
            st_d.pend  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st_q   <= ResetSt;
            tick_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            tick_q <= tick_d;
        end
    end

    assign busy_o = st_q.pend;
    assign tick_o = tick_q;

`ifdef FAB_CLK_EN_GEN_TOGGLE_EN
    logic tgl_q, tgl_d;

    always_comb begin
        tgl_d = tgl_q ^ tick_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tgl_q <= 1'b0;
        end else begin
            tgl_q <= tgl_d;
        end
    end

    assign tgl_o = tgl_q;
`else
    assign tgl_o = 1'b0;
`endif

endmodule

// File: rtl/fab_clk_en_gen.sv
// Multi-channel clock-enable generator with runtime divisors applied at terminal count.
// Define FAB_CLK_EN_GEN_TOGGLE_EN to build the CLK_TGL divide-by-2 outputs.
module fab_clk_en_gen
    import fab_clk_en_gen_pkg::*;
#(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned DIV_W   = FAB_CLK_DIV_W,
    parameter int unsigned DEF_DIV = FAB_CLK_DEF_DIV,
    localparam int unsigned SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [N_CH-1:0]  ENABLE,
    input  logic             SYNC,
    input  logic             DIV_WR,
    input  logic [SEL_W-1:0] DIV_SEL,
    input  logic [DIV_W-1:0] DIV_DATA,
    output logic [N_CH-1:0]  DIV_BUSY,
    output logic [N_CH-1:0]  TICK,
    output logic [N_CH-1:0]  CLK_TGL
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic wr;

        // Out-of-range selects match no channel and are dropped.
        assign wr = DIV_WR && (DIV_SEL == SEL_W'(i));

        fab_clk_en_ch #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk_i     (CLK),
            .rst_i     (RESET),
            .en_i      (ENABLE[i]),
            .sync_i    (SYNC),
            .wr_i      (wr),
            .wr_data_i (DIV_DATA),
            .busy_o    (DIV_BUSY[i]),
            .tick_o    (TICK[i]),
            .tgl_o     (CLK_TGL[i])
        );
    end

endmodule

// File: tb/tb_fab_clk_en_gen.sv
// Bench for fab_clk_en_gen: directed scenarios then random traffic against a tick-schedule model.
// Honours FAB_CLK_EN_GEN_TOGGLE_EN for the expected CLK_TGL behaviour.
module tb_fab_clk_en_gen;

    localparam int N_CH    = 4;
    localparam int DEF_DIV = 50;
`ifdef FAB_CLK_EN_GEN_TOGGLE_EN
    localparam bit TglEn = 1'b1;
`else
    localparam bit TglEn = 1'b0;
`endif

    logic            CLK = 1'b0;
    logic            RESET;
    logic [3:0]      ENABLE;
    logic            SYNC;
    logic            DIV_WR;
    logic [1:0]      DIV_SEL;
    logic [15:0]     DIV_DATA;
    logic [3:0]      DIV_BUSY;
    logic [3:0]      TICK;
    logic [3:0]      CLK_TGL;

    fab_clk_en_gen #(
        .N_CH    (N_CH),
        .DIV_W   (16),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .ENABLE   (ENABLE),
        .SYNC     (SYNC),
        .DIV_WR   (DIV_WR),
        .DIV_SEL  (DIV_SEL),
        .DIV_DATA (DIV_DATA),
        .DIV_BUSY (DIV_BUSY),
        .TICK     (TICK),
        .CLK_TGL  (CLK_TGL)
    );

    always #5 CLK = ~CLK;

    // Model: each channel keeps the absolute edge number of its next tick.
    int         m_div_a [N_CH];
    int         m_div_p [N_CH];
    bit         m_pend  [N_CH];
    int         m_due   [N_CH];
    logic [3:0] m_tick, m_tgl;
    int         cyc, total, bad;

    task automatic mdl_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_div_a[c] = DEF_DIV;
            m_div_p[c] = DEF_DIV;
            m_pend[c]  = 1'b0;
            m_due[c]   = cyc + DEF_DIV;
        end
        m_tick = '0;
        m_tgl  = '0;
    endtask

    task automatic mdl_apply(input int c);
        if (m_pend[c]) begin
            m_div_a[c] = m_div_p[c];
            m_pend[c]  = 1'b0;
        end
        m_due[c] = cyc + m_div_a[c];
    endtask

    task automatic mdl_edge();
        for (int c = 0; c < N_CH; c++) begin
            bit t;
            t = 1'b0;
            if (SYNC || !ENABLE[c]) begin
                mdl_apply(c);
            end else if (m_div_a[c] == 0) begin
                if (m_pend[c]) mdl_apply(c);
            end else if (cyc == m_due[c]) begin
                t = 1'b1;
                mdl_apply(c);
            end
            if (DIV_WR && int'(DIV_SEL) == c) begin
                m_div_p[c] = int'(DIV_DATA);
                m_pend[c]  = 1'b1;
            end
            m_tick[c] = t;
            if (TglEn && t) m_tgl[c] = ~m_tgl[c];
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // One clock: DUT and model see the same inputs, outputs compared at the falling edge.
    task automatic tick_cycle();
        logic [3:0] exp_busy;
        @(posedge CLK);
        cyc++;
        mdl_edge();
        @(negedge CLK);
        for (int c = 0; c < N_CH; c++) exp_busy[c] = m_pend[c];
        chk("tick", 32'(TICK), 32'(m_tick));
        chk("busy", 32'(DIV_BUSY), 32'(exp_busy));
        chk("tgl", 32'(CLK_TGL), 32'(m_tgl));
        DIV_WR = 1'b0;
        SYNC   = 1'b0;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick_cycle();
    endtask

    task automatic wr_div(input int ch, input int val);
        DIV_WR   = 1'b1;
        DIV_SEL  = 2'(ch);
        DIV_DATA = 16'(val);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        RESET    = 1'b1;
        ENABLE   = 4'hF;
        SYNC     = 1'b0;
        DIV_WR   = 1'b0;
        DIV_SEL  = '0;
        DIV_DATA = '0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        mdl_reset();
        chk("rst_tick", 32'(TICK), 32'h0);
        chk("rst_busy", 32'(DIV_BUSY), 32'h0);
        chk("rst_tgl", 32'(CLK_TGL), 32'h0);

        // Defaults, then ch1 rewritten mid-period.
        run_to(19);
        wr_div(1, 10);
        tick_cycle();
        chk("busy1_after_wr", 32'(DIV_BUSY[1]), 32'h1);
        run_to(30);
        chk("no_tick1_30", 32'(TICK[1]), 32'h0);
        run_to(40);
        chk("no_tick1_40", 32'(TICK[1]), 32'h0);
        run_to(50);
        chk("first_tick_50", 32'(TICK), 32'hF);
        chk("busy1_clear_50", 32'(DIV_BUSY[1]), 32'h0);
        run_to(60);
        chk("ch1_tick_60", 32'(TICK), 32'h2);

        // Two writes to ch2 before its terminal count: only the last survives.
        run_to(61);
        wr_div(2, 7);
        run_to(64);
        wr_div(2, 3);
        run_to(100);
        chk("all_tick_100", 32'(TICK), 32'hF);
        run_to(103);
        chk("ch2_tick_103", 32'(TICK), 32'h4);
        run_to(106);
        chk("ch2_tick_106", 32'(TICK), 32'h4);

        // SYNC with ch0 pending 5.
        run_to(109);
        wr_div(0, 5);
        run_to(114);
        SYNC = 1'b1;
        tick_cycle();
        chk("sync_kills_tick", 32'(TICK), 32'h0);
        run_to(120);
        chk("ch0_tick_120", 32'(TICK), 32'h1);
        run_to(170);

        // ch3 parked at divisor 0, enable toggled, then divisor 1.
        wr_div(3, 0);
        tick_cycle();
        ENABLE = 4'h7;
        run_to(175);
        ENABLE = 4'hF;
        for (int k = 0; k < 20; k++) begin
            tick_cycle();
            chk("parked_no_tick", 32'(TICK[3]), 32'h0);
        end
        wr_div(3, 1);
        tick_cycle();
        tick_cycle();
        for (int k = 0; k < 10; k++) begin
            tick_cycle();
            chk("div1_tick_high", 32'(TICK[3]), 32'h1);
        end

        // Divisor 4 on ch0 for the toggle output, then async reset mid-high.
        wr_div(0, 4);
        tick_cycle();
        SYNC = 1'b1;
        tick_cycle();
        for (int k = 0; k < 24; k++) tick_cycle();
        for (int k = 0; k < 16 && (TglEn && m_tgl[0] != 1'b1); k++) tick_cycle();
        wr_div(1, 9);
        tick_cycle();
        @(posedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        chk("async_rst_tick", 32'(TICK), 32'h0);
        chk("async_rst_busy", 32'(DIV_BUSY), 32'h0);
        chk("async_rst_tgl", 32'(CLK_TGL), 32'h0);
        @(negedge CLK);
        RESET = 1'b0;
        mdl_reset();

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < N_CH; c++) ENABLE[c] = ($urandom_range(0, 19) != 0);
            SYNC    = ($urandom_range(0, 39) == 0);
            DIV_WR  = ($urandom_range(0, 6) == 0);
            DIV_SEL = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 7) DIV_DATA = 16'($urandom_range(0, 12));
            else DIV_DATA = 16'($urandom_range(0, 300));
            tick_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
